// File: rtl/hazard_ctrl_pipe.sv
// Fetch/decode hazard controller: load-use detection over a shift pipe of in-flight
// load destinations, plus a branch/JR PC-hold FSM. Optional stall counter: HAZARD_PERF_CNT_EN.
module hazard_ctrl_pipe #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned OP_W       = 6,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     fetch_op,
  input  logic [REG_W-1:0]    fetch_rs1,
  input  logic [REG_W-1:0]    fetch_rs2,
  input  logic                decode_valid,
  input  logic [OP_W-1:0]     decode_op,
  input  logic [REG_W-1:0]    decode_rd,
  input  logic                decode_wr_en,
  input  logic                br_resolved,
  output logic                need_nop,
  output logic                pc_stall,
  output logic [LOAD_LAT-1:0] load_window,
  output logic [CNT_W-1:0]    stall_cycles
);

  typedef enum logic {IDLE, BR_WAIT} state_t;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       dec_load, live_win, live_hit, pipe_hit, load_hit, br_op_hit;
  logic       fetch_br, fetch_jr;

  assign fetch_br = (fetch_op >= OP_W'(32'h04)) && (fetch_op <= OP_W'(32'h07));
  assign fetch_jr = (fetch_op == OP_W'(32'h12)) || (fetch_op == OP_W'(32'h13));

  // A load to r0 is never tracked, so r0 can never produce a hit downstream.
  assign dec_load = decode_valid && (decode_op >= OP_W'(32'h20)) &&
                    (decode_op <= OP_W'(32'h27)) && (decode_rd != '0);
  assign live_win = dec_load && !reset;
  assign live_hit = dec_load && ((decode_rd == fetch_rs1) || (decode_rd == fetch_rs2));
  assign load_hit = live_hit || pipe_hit;

  assign br_op_hit = fetch_br && decode_valid && decode_wr_en &&
                     (decode_rd != '0) && (fetch_rs1 == decode_rd);

  generate
    if (LOAD_LAT > 1) begin : g_pipe
      localparam int unsigned N = LOAD_LAT - 1;
      logic [N-1:0]     vld;
      logic [REG_W-1:0] rd [N];

      // Unconditional shift; bubbles enter as invalid entries.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld <= '0;
          for (int k = 0; k < int'(N); k++) rd[k] <= '0;
        end else begin
          vld[0] <= dec_load;
          rd[0]  <= decode_rd;
          for (int k = 1; k < int'(N); k++) begin
            vld[k] <= vld[k-1];
            rd[k]  <= rd[k-1];
          end
        end
      end

      always_comb begin
        pipe_hit = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
          if (vld[k] && ((rd[k] == fetch_rs1) || (rd[k] == fetch_rs2))) pipe_hit = 1'b1;
        end
      end

      assign load_window = {vld, live_win};
    end else begin : g_no_pipe
      assign pipe_hit    = 1'b0;
      assign load_window = live_win;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs are held low for the whole reset cycle regardless of stale state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    need_nop = 1'b0;
    pc_stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (load_hit || br_op_hit) begin
            need_nop = 1'b1;
            pc_stall = 1'b1;
          end else if (fetch_br || fetch_jr) begin
            pc_stall = 1'b1;
            state_nx = BR_WAIT;
            cnt_nx   = 3'(BR_PENALTY);
          end
        end
        BR_WAIT: begin
          need_nop = 1'b1;
          pc_stall = 1'b1;
          if (br_resolved || (cnt == 3'd1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (pc_stall && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
